// File: rtl/hls_perf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hls_perf_pkg
//  Description : Shared types and constants for the HLS handshake performance
//                monitor: read-port counter select encoding, per-channel
//                activity state encoding and status word bit positions.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package hls_perf_pkg;

    // Counter select presented on rd_sel; code 7 is unused and reads as 0.
    typedef enum logic [2:0] {
        SEL_TXN    = 3'd0,
        SEL_LAST   = 3'd1,
        SEL_MIN    = 3'd2,
        SEL_MAX    = 3'd3,
        SEL_STALL  = 3'd4,
        SEL_BUSY   = 3'd5,
        SEL_STATUS = 3'd6
    } rd_sel_e;

    // Per-channel activity state.
    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_RUN   = 2'd1,
        CH_DRAIN = 2'd2
    } ch_state_e;

    // Status word layout: {overflow, orphan, occupancy[7:0]}.
    localparam int c_STAT_OCC_W      = 8;
    localparam int c_STAT_ORPHAN_BIT = 8;
    localparam int c_STAT_OVF_BIT    = 9;

endpackage
`default_nettype wire

// File: rtl/hls_perf_ts_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : hls_perf_ts_fifo
//  Description : Start-timestamp FIFO for one monitored channel. Holds the
//                start time of every outstanding transaction so overlapped
//                (dataflow) transactions each get their own latency.
//                A push and pop in the same cycle on an empty FIFO bypass the
//                storage: o_head shows i_din and the FIFO stays empty.
//                A push while full is accepted only if a pop happens too.
//  Ports       : clock, reset (async, active-low), clear (sync)
//                i_push / i_pop / i_din      : requests and push data
//                o_head                      : head entry (or i_din if empty)
//                o_occ / o_occ_next          : occupancy now / after this cycle
//                o_full / o_empty            : occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module hls_perf_ts_fifo #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TS_W            = 24,
    localparam int PTR_W          = $clog2(MAX_OUTSTANDING),
    localparam int OCC_W          = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [TS_W-1:0]  i_din,
    output logic [TS_W-1:0]  o_head,
    output logic [OCC_W-1:0] o_occ,
    output logic [OCC_W-1:0] o_occ_next,
    output logic             o_full,
    output logic             o_empty
);

    logic [TS_W-1:0]  r_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_do_push;
    logic w_do_pop;
    logic [OCC_W-1:0] w_occ_next;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OCC_W'(MAX_OUTSTANDING));
    assign w_bypass  = i_push & i_pop & w_empty;
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push writes into.
    assign w_do_push = i_push & ~w_bypass & (~w_full | w_do_pop);

    assign w_occ_next = r_occ + OCC_W'(w_do_push) - OCC_W'(w_do_pop);

    assign o_head     = w_empty ? i_din : r_mem[r_rd_ptr];
    assign o_occ      = r_occ;
    assign o_occ_next = w_occ_next;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

    // Pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ <= w_occ_next;
        end
    end

    // Storage needs no reset: entries are only read while occupied.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule
`default_nettype wire

// File: rtl/hls_handshake_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : hls_handshake_perf_monitor
//  Description : On-chip performance monitor for NUM_CH HLS block-level
//                handshakes. Per channel it keeps transaction count,
//                last/min/max start-to-done latency, stall and busy cycles
//                and sticky overflow/orphan flags, readable through a
//                registered 1-cycle-latency read port.
//  Ports       : clock, reset (async, active-low)
//                enable / finish / clear : measurement control
//                ap_start/ap_ready/ap_done/ap_continue : per-channel taps
//                rd_en, rd_ch, rd_sel -> rd_valid, rd_data : read port
//                frozen  : measurement frozen by finish
//                err_any : OR of all per-channel sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module hls_handshake_perf_monitor #(
    parameter int NUM_CH          = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TS_W            = 24,
    parameter int CNT_W           = 32,
    localparam int RD_CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               finish,
    input  logic               clear,
    input  logic [NUM_CH-1:0]  ap_start,
    input  logic [NUM_CH-1:0]  ap_ready,
    input  logic [NUM_CH-1:0]  ap_done,
    input  logic [NUM_CH-1:0]  ap_continue,
    input  logic               rd_en,
    input  logic [RD_CH_W-1:0] rd_ch,
    input  logic [2:0]         rd_sel,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               frozen,
    output logic               err_any
);

    import hls_perf_pkg::*;

    localparam int OCC_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [TS_W-1:0]  r_ts_now;
    logic             r_frozen;
    logic             w_upd;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;
    logic [CNT_W-1:0] w_rd_mux;
    logic [CNT_W-1:0] w_rd_val [NUM_CH];
    logic [NUM_CH-1:0] w_err;

    // Free-running timestamp; neither clear nor freeze stops it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_ts_now <= '0;
        else        r_ts_now <= r_ts_now + TS_W'(1);
    end

    // finish freezes in the very cycle it is first seen, hence the OR with
    // the raw input in the update gate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      r_frozen <= 1'b0;
        else if (clear)  r_frozen <= 1'b0;
        else if (finish) r_frozen <= 1'b1;
    end

    assign w_upd   = enable & ~(r_frozen | finish) & ~clear;
    assign frozen  = r_frozen;
    assign err_any = |w_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             w_start;
        logic             w_end;
        logic             w_stall;
        logic             w_lat_ok;
        logic             w_full;
        logic             w_empty;
        logic [TS_W-1:0]  w_head;
        logic [TS_W-1:0]  w_lat;
        logic [OCC_W-1:0] w_occ;
        logic [OCC_W-1:0] w_occ_next;
        logic [CNT_W-1:0] r_txn;
        logic [CNT_W-1:0] r_stall;
        logic [CNT_W-1:0] r_busy;
        logic [TS_W-1:0]  r_lat_last;
        logic [TS_W-1:0]  r_lat_min;
        logic [TS_W-1:0]  r_lat_max;
        logic             r_ovf;
        logic             r_orphan;
        logic [CNT_W-1:0] w_status;
        logic [CNT_W-1:0] w_sel_val;
        ch_state_e        r_state;
        ch_state_e        w_state_next;

        assign w_start = ap_start[g] & ap_ready[g] & w_upd;
        assign w_end   = ap_done[g] & ap_continue[g] & w_upd;
        assign w_stall = ap_done[g] & ~ap_continue[g] & w_upd;

        hls_perf_ts_fifo #(
            .MAX_OUTSTANDING (MAX_OUTSTANDING),
            .TS_W            (TS_W)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear),
            .i_push     (w_start),
            .i_pop      (w_end),
            .i_din      (r_ts_now),
            .o_head     (w_head),
            .o_occ      (w_occ),
            .o_occ_next (w_occ_next),
            .o_full     (w_full),
            .o_empty    (w_empty)
        );

        // On bypass the head is ts_now itself, so the latency comes out 0.
        assign w_lat    = r_ts_now - w_head;
        assign w_lat_ok = w_end & (~w_empty | w_start);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_txn      <= '0;
                r_stall    <= '0;
                r_busy     <= '0;
                r_lat_last <= '0;
                r_lat_min  <= '1;
                r_lat_max  <= '0;
                r_ovf      <= 1'b0;
                r_orphan   <= 1'b0;
            end else if (clear) begin
                r_txn      <= '0;
                r_stall    <= '0;
                r_busy     <= '0;
                r_lat_last <= '0;
                r_lat_min  <= '1;
                r_lat_max  <= '0;
                r_ovf      <= 1'b0;
                r_orphan   <= 1'b0;
            end else begin
                if (w_end && (r_txn != '1))
                    r_txn <= r_txn + CNT_W'(1);
                if (w_stall && (r_stall != '1))
                    r_stall <= r_stall + CNT_W'(1);
                if (w_upd && !w_empty && (r_busy != '1))
                    r_busy <= r_busy + CNT_W'(1);
                if (w_lat_ok) begin
                    r_lat_last <= w_lat;
                    if (w_lat < r_lat_min) r_lat_min <= w_lat;
                    if (w_lat > r_lat_max) r_lat_max <= w_lat;
                end
                if (w_end && w_empty && !w_start)
                    r_orphan <= 1'b1;
                if (w_start && w_full && !w_end)
                    r_ovf <= 1'b1;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset)     r_state <= CH_IDLE;
            else if (clear) r_state <= CH_IDLE;
            else            r_state <= w_state_next;
        end

        // An end decides by what is left outstanding after this cycle.
        always_comb begin
            w_state_next = r_state;
            if (w_end)
                w_state_next = (w_occ_next != '0) ? CH_RUN : CH_IDLE;
            else if (w_stall && (r_state == CH_RUN))
                w_state_next = CH_DRAIN;
            else if (w_start && (r_state == CH_IDLE))
                w_state_next = CH_RUN;
        end

        always_comb begin
            w_status = '0;
            w_status[c_STAT_OCC_W-1:0]   = c_STAT_OCC_W'(w_occ);
            w_status[c_STAT_ORPHAN_BIT]  = r_orphan;
            w_status[c_STAT_OVF_BIT]     = r_ovf;
        end

        always_comb begin
            w_sel_val = '0;
            case (rd_sel_e'(rd_sel))
                SEL_TXN:    w_sel_val = r_txn;
                SEL_LAST:   w_sel_val = CNT_W'(r_lat_last);
                SEL_MIN:    w_sel_val = CNT_W'(r_lat_min);
                SEL_MAX:    w_sel_val = CNT_W'(r_lat_max);
                SEL_STALL:  w_sel_val = r_stall;
                SEL_BUSY:   w_sel_val = r_busy;
                SEL_STATUS: w_sel_val = w_status;
                default:    w_sel_val = '0;
            endcase
        end

        assign w_rd_val[g] = w_sel_val;
        assign w_err[g]    = r_ovf | r_orphan;
    end

    always_comb begin
        w_rd_mux = '0;
        if (int'(rd_ch) < NUM_CH) w_rd_mux = w_rd_val[rd_ch];
    end

    // Read data captures pre-update counter values and holds between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire
